// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter that shares one AES core among NUM_REQ job sources.
// Optional watchdog in BUSY is enabled by defining AES_ARB_TIMEOUT_EN.
module aes_job_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 127
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [2*NUM_REQ-1:0]       req_mode,
    input  logic [NUM_REQ-1:0]         req_enc_dec,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       core_start,
    output logic [1:0]                 core_mode,
    output logic                       core_enc_dec,
    output logic [3:0]                 core_round_amount,
    input  logic                       core_done,
    output logic                       core_reset,
    output logic                       busy,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       rsp_err
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("aes_job_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cur_id;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;
    logic             timed_out;
`endif

    logic [1:0]      mode_arr [NUM_REQ];
    logic            pick_found;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] scan_id;
    logic [1:0]      pick_mode;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_mode
        assign mode_arr[g] = req_mode[2*g+1:2*g];
    end

    function automatic logic [3:0] rounds_for(input logic [1:0] m);
        case (m)
            2'b00:   rounds_for = 4'hA;
            2'b01:   rounds_for = 4'hC;
            2'b10:   rounds_for = 4'hE;
            default: rounds_for = 4'h0;
        endcase
    endfunction

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_id    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_id = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!pick_found && req[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
        pick_mode = mode_arr[pick_id];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            cur_id            <= '0;
            req_ack           <= '0;
            core_start        <= 1'b0;
            core_mode         <= 2'b00;
            core_enc_dec      <= 1'b0;
            core_round_amount <= 4'h0;
            core_reset        <= 1'b0;
            busy              <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_id            <= '0;
            rsp_err           <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            wd_cnt            <= '0;
            timed_out         <= 1'b0;
`endif
        end else begin
            req_ack    <= '0;
            core_start <= 1'b0;
            core_reset <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        cur_id            <= pick_id;
                        req_ack           <= NUM_REQ'(1) << pick_id;
                        core_mode         <= pick_mode;
                        core_enc_dec      <= req_enc_dec[pick_id];
                        core_round_amount <= rounds_for(pick_mode);
                        busy              <= 1'b1;
                        // Illegal key size never reaches the core.
                        if (pick_mode == 2'b11) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_id    <= pick_id;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    core_start <= 1'b1;
                    state      <= BUSY;
`ifdef AES_ARB_TIMEOUT_EN
                    wd_cnt     <= '0;
                    timed_out  <= 1'b0;
`endif
                end
                BUSY: begin
`ifdef AES_ARB_TIMEOUT_EN
                    if (timed_out) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_id    <= cur_id;
                        timed_out <= 1'b0;
                    end else if (core_done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                    end else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        core_reset <= 1'b1;
                        timed_out  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
`else
                    if (core_done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                    end
`endif
                end
                RESP: begin
                    rr_ptr <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(cur_id + 1'b1);
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
